qenc_dqp_bin: RTL and testbench
===============================

# qenc_dqp_bin

Encoder-side binarizer for the HEVC `cu_qp_delta_abs` / `cu_qp_delta_sign_flag` syntax elements. It is the transmitting counterpart of the decoder's delta-QP bin-request FSM. It takes a signed delta-QP value on `dqp_start` and emits the bin sequence one bin per handshake to the CABAC arithmetic encoder: context-coded TU prefix, bypass EG0 suffix, bypass sign. It sits under the encoder TU FSM, which muxes its bin/context outputs onto the shared encoder-engine port.

## Interface
- `CTX_DQP_BASE`, default 10'd180, context-memory base address of the `cu_qp_delta_abs` context set (2 contexts per initType, 3 initTypes).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `dqp_start`  in  1  one-cycle start pulse, sampled only in IDLE.
- `dqp_val`  in  7  signed delta QP, range −64..+63; sampled with `dqp_start`.
- `slice_type`  in  2  0=B, 1=P, 2=I; sampled with `dqp_start`.
- `cabac_init_flag`  in  1  sampled with `dqp_start`.
- `ctx_enc_addr`  out  10  context address of the current bin; don't-care when `EPMode_enc`=1.
- `bin_val`  out  1  current bin value.
- `bin_vld`  out  1  bin offered to the engine.
- `EPMode_enc`  out  1  1 = bypass bin.
- `enc_rdy`  in  1  engine accepts the offered bin this cycle.
- `dqp_done_intr`  out  1  one-cycle pulse after the last bin has been accepted.

## Operation
- **initType:**
  - I → 0.
  - P → `cabac_init_flag` ? 2 : 1.
  - B → `cabac_init_flag` ? 1 : 2.
  - slice_type 3 is treated as I.
- **Context address:** `CTX_DQP_BASE + 2*initType + ctxInc`. ctxInc = 0 for prefix bin 0 and 1 for prefix bins 1..4.
- **Magnitude:** abs = |dqp_val|, 7-bit unsigned (−64 → 64). prefixVal = min(abs,5).
- **States:** IDLE, PREFIX, SUF_UNARY, SUF_BITS, SIGN, DONE.
- **IDLE:**
  - On `dqp_start`, latch abs, sign and initType.
  - Go to PREFIX with bin index 0.
- **PREFIX:** context-coded.
  - Bin i (i < prefixVal) = 1.
  - If prefixVal < 5, bin prefixVal = 0, terminating the prefix.
  - After the last prefix bin is accepted:
    - abs ≥ 5 → SUF_UNARY, with suf = abs−5 (6 bits) and k = 0 (3 bits).
    - otherwise abs > 0 → SIGN.
    - otherwise (abs = 0) → DONE.
- **SUF_UNARY:** bypass, EG0 (k0 = 0).
  - While suf ≥ (1<<k): emit 1, then suf −= 1<<k and k++.
  - Else: emit 0 and go to SUF_BITS, or to SIGN if k = 0.
- **SUF_BITS:** bypass. Emit the k LSBs of suf, MSB first. Then → SIGN.
- **SIGN:** bypass. Emit 1 for negative, 0 for positive. Then → DONE.
- **DONE:** `bin_vld`=0, `dqp_done_intr`=1 for one cycle, then → IDLE.
- `dqp_start` outside IDLE is ignored. Inputs are not re-sampled mid-element.
- Maximum element length: 5 prefix + 11 suffix + 1 sign = 17 bins.

## Timing
- **Reset values:** state IDLE; `bin_vld`, `bin_val`, `EPMode_enc`, `dqp_done_intr` = 0; `ctx_enc_addr` = 0.
- All outputs are registered.
- **Start latency:** `dqp_start` at cycle T → first bin offered (`bin_vld`=1) at T+1.
- **Handshake:** transfer happens on a cycle with `bin_vld` & `enc_rdy`.
  - While `enc_rdy`=0, `bin_val`, `ctx_enc_addr` and `EPMode_enc` are held stable.
  - After a transfer at cycle C, the next bin is offered at C+1 with no bubble. Sustained `enc_rdy`=1 gives 1 bin/cycle.
- **Done:** last transfer at cycle C → `bin_vld`=0 and `dqp_done_intr`=1 at C+1. IDLE at C+2, where a new `dqp_start` is accepted.
- **Back-pressure:** `enc_rdy` may toggle arbitrarily. No bin is dropped or duplicated.
- **Reset mid-element:** `rst` at any state → IDLE next cycle, all outputs 0, no `dqp_done_intr`. Partial bin sequence is abandoned.
- `enc_rdy` high while `bin_vld`=0 has no effect.

## Test plan
- **dqp=0, I slice, `enc_rdy` tied 1:** exactly 1 bin, 0, ctx `CTX_DQP_BASE`+0, `EPMode_enc`=0. Done pulse at the cycle after the transfer.
- **dqp=+3, P slice, cabac_init_flag=0:**
  - Context bins 1,1,1,0 at ctx base+2, +3, +3, +3.
  - Then bypass sign 0.
  - 5 bins, done.
- **dqp=−7, B slice, cabac_init_flag=0:**
  - Context bins 1,1,1,1,1 at base+4, +5×4.
  - Then bypass 1,0,1 (EG0 of 2), then sign 1.
  - 9 bins total.
- **dqp=−64:**
  - Prefix 11111.
  - Then bypass 1,1,1,1,1,0,1,1,1,0,0 (suffix 59).
  - Then sign 1.
  - 17 bins total.
- **dqp=+5 with random `enc_rdy`** (≈50% duty, stalls up to 8 cycles): bins 11111, then 0 (EG0 of 0), then sign 0. Outputs stable during every stall; done after the 7th transfer.
- **`rst` asserted mid-suffix:** IDLE next cycle, outputs 0, no done. A following `dqp_start` with dqp=+1 yields bins 1,0 (ctx), 0 (bypass).

Source files
------------

// File: rtl/qenc_dqp_bin.sv
// cu_qp_delta_abs/sign binarizer: TU prefix (ctx), EG0 suffix + sign (bypass), one bin per enc_rdy handshake.
// First bin one cycle after dqp_start; bins held stable while enc_rdy is low; done pulse the cycle after the last transfer.
module qenc_dqp_bin #(
   parameter logic [9:0] CTX_DQP_BASE = 10'd180
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dqp_start,
   input  logic [6:0] dqp_val,
   input  logic [1:0] slice_type,
   input  logic       cabac_init_flag,
   output logic [9:0] ctx_enc_addr,
   output logic       bin_val,
   output logic       bin_vld,
   output logic       EPMode_enc,
   input  logic       enc_rdy,
   output logic       dqp_done_intr
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PREFIX    = 3'd1,
      S_SUF_UNARY = 3'd2,
      S_SUF_BITS  = 3'd3,
      S_SIGN      = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [6:0] abs_q, abs_d;
   logic       neg_q, neg_d;
   logic [1:0] init_q, init_d;
   logic [2:0] idx_q, idx_d;
   logic [5:0] suf_q, suf_d;
   logic [2:0] k_q, k_d;
   logic [2:0] bidx_q, bidx_d;

   logic       vld_q, vld_d;
   logic       val_q, val_d;
   logic       ep_q, ep_d;
   logic [9:0] ctx_q, ctx_d;
   logic       done_q, done_d;

   logic       xfer;
   logic [2:0] pfx_last;
   logic [6:0] step_q;
   logic [2:0] pfx_d;
   logic [6:0] step_d;
   logic [5:0] suf_sh;

   always_comb begin
      state_d  = state_q;
      abs_d    = abs_q;
      neg_d    = neg_q;
      init_d   = init_q;
      idx_d    = idx_q;
      suf_d    = suf_q;
      k_d      = k_q;
      bidx_d   = bidx_q;
      xfer     = vld_q & enc_rdy;
      // abs < 5 ends with a zero at index abs; otherwise the prefix is five ones
      pfx_last = (abs_q >= 7'd5) ? 3'd4 : abs_q[2:0];
      step_q   = 7'd1 << k_q;

      case (state_q)
         S_IDLE: begin
            if (dqp_start) begin
               abs_d = dqp_val[6] ? (~dqp_val + 7'd1) : dqp_val;
               neg_d = dqp_val[6];
               case (slice_type)
                  2'd0:    init_d = cabac_init_flag ? 2'd1 : 2'd2;
                  2'd1:    init_d = cabac_init_flag ? 2'd2 : 2'd1;
                  default: init_d = 2'd0;
               endcase
               idx_d   = 3'd0;
               state_d = S_PREFIX;
            end
         end
         S_PREFIX: begin
            if (xfer) begin
               if (idx_q == pfx_last) begin
                  if (abs_q >= 7'd5) begin
                     suf_d   = 6'(abs_q - 7'd5);
                     k_d     = 3'd0;
                     state_d = S_SUF_UNARY;
                  end else if (abs_q != 7'd0) begin
                     state_d = S_SIGN;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         S_SUF_UNARY: begin
            if (xfer) begin
               if ({1'b0, suf_q} >= step_q) begin
                  suf_d = suf_q - step_q[5:0];
                  k_d   = k_q + 3'd1;
               end else if (k_q == 3'd0) begin
                  state_d = S_SIGN;
               end else begin
                  bidx_d  = k_q;
                  state_d = S_SUF_BITS;
               end
            end
         end
         S_SUF_BITS: begin
            if (xfer) begin
               if (bidx_q == 3'd1) state_d = S_SIGN;
               else                bidx_d  = bidx_q - 3'd1;
            end
         end
         S_SIGN: begin
            if (xfer) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are computed from the next state so they can be registered with no extra latency
      vld_d  = 1'b0;
      val_d  = 1'b0;
      ep_d   = 1'b0;
      ctx_d  = 10'd0;
      done_d = 1'b0;
      pfx_d  = (abs_d >= 7'd5) ? 3'd5 : abs_d[2:0];
      step_d = 7'd1 << k_d;
      suf_sh = suf_d >> (bidx_d - 3'd1);

      case (state_d)
         S_PREFIX: begin
            vld_d = 1'b1;
            val_d = (idx_d < pfx_d);
            ctx_d = CTX_DQP_BASE + {7'd0, init_d, 1'b0} + {9'd0, (idx_d != 3'd0)};
         end
         S_SUF_UNARY: begin
            vld_d = 1'b1;
            ep_d  = 1'b1;
            val_d = ({1'b0, suf_d} >= step_d);
         end
         S_SUF_BITS: begin
            vld_d = 1'b1;
            ep_d  = 1'b1;
            val_d = suf_sh[0];
         end
         S_SIGN: begin
            vld_d = 1'b1;
            ep_d  = 1'b1;
            val_d = neg_d;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         abs_q   <= 7'd0;
         neg_q   <= 1'b0;
         init_q  <= 2'd0;
         idx_q   <= 3'd0;
         suf_q   <= 6'd0;
         k_q     <= 3'd0;
         bidx_q  <= 3'd0;
         vld_q   <= 1'b0;
         val_q   <= 1'b0;
         ep_q    <= 1'b0;
         ctx_q   <= 10'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         abs_q   <= abs_d;
         neg_q   <= neg_d;
         init_q  <= init_d;
         idx_q   <= idx_d;
         suf_q   <= suf_d;
         k_q     <= k_d;
         bidx_q  <= bidx_d;
         vld_q   <= vld_d;
         val_q   <= val_d;
         ep_q    <= ep_d;
         ctx_q   <= ctx_d;
         done_q  <= done_d;
      end
   end

   assign ctx_enc_addr  = ctx_q;
   assign bin_val       = val_q;
   assign bin_vld       = vld_q;
   assign EPMode_enc    = ep_q;
   assign dqp_done_intr = done_q;

endmodule

// File: tb/tb_qenc_dqp_bin.sv
// Bench for qenc_dqp_bin: reference bin list from the delta-QP binarization rules, checked per handshake.
module tb_qenc_dqp_bin;

   localparam int BASE = 180;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dqp_start = 1'b0;
   logic [6:0] dqp_val = 7'd0;
   logic [1:0] slice_type = 2'd0;
   logic       cabac_init_flag = 1'b0;
   logic [9:0] ctx_enc_addr;
   logic       bin_val;
   logic       bin_vld;
   logic       EPMode_enc;
   logic       enc_rdy = 1'b0;
   logic       dqp_done_intr;

   qenc_dqp_bin #(.CTX_DQP_BASE(10'd180)) dut (
      .clk            (clk),
      .rst            (rst),
      .dqp_start      (dqp_start),
      .dqp_val        (dqp_val),
      .slice_type     (slice_type),
      .cabac_init_flag(cabac_init_flag),
      .ctx_enc_addr   (ctx_enc_addr),
      .bin_val        (bin_val),
      .bin_vld        (bin_vld),
      .EPMode_enc     (EPMode_enc),
      .enc_rdy        (enc_rdy),
      .dqp_done_intr  (dqp_done_intr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic       ep;
      logic [9:0] ctx;
   } bin_t;

   bin_t tmp_q[$];
   bin_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int xfer_cnt = 0;
   int done_cnt = 0;
   bit pend_done = 0;
   int rdy_mode = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: TU prefix of min(abs,5), EG0 of abs-5 written as n ones, 0, n LSBs of (v+1), then sign
   function automatic int build(input int dqp, input int st, input int f);
      int a, it, p, plen, x, n;
      bin_t b;
      tmp_q.delete();
      a  = (dqp < 0) ? -dqp : dqp;
      it = (st == 1) ? (f ? 2 : 1) : (st == 0) ? (f ? 1 : 2) : 0;
      p  = (a < 5) ? a : 5;
      plen = (a < 5) ? a + 1 : 5;
      for (int i = 0; i < plen; i++) begin
         b.v = (i < p); b.ep = 1'b0; b.ctx = 10'(BASE + 2 * it + ((i > 0) ? 1 : 0));
         tmp_q.push_back(b);
      end
      if (a >= 5) begin
         x = a - 5 + 1;
         n = 0;
         while ((1 << (n + 1)) <= x) n++;
         for (int i = 0; i < n; i++) begin
            b.v = 1'b1; b.ep = 1'b1; b.ctx = 10'd0; tmp_q.push_back(b);
         end
         b.v = 1'b0; b.ep = 1'b1; b.ctx = 10'd0; tmp_q.push_back(b);
         for (int j = n - 1; j >= 0; j--) begin
            b.v = x[j]; b.ep = 1'b1; b.ctx = 10'd0; tmp_q.push_back(b);
         end
      end
      if (a > 0) begin
         b.v = (dqp < 0); b.ep = 1'b1; b.ctx = 10'd0; tmp_q.push_back(b);
      end
      return tmp_q.size();
   endfunction

   function automatic int pack_vals();
      int r = 0;
      foreach (tmp_q[i]) r = (r << 1) | int'(tmp_q[i].v);
      return r;
   endfunction

   task automatic pin(input string nm, input int dqp, input int st, input int f,
                      input int len, input int vals);
      int n;
      n = build(dqp, st, f);
      chk({nm, "_len"}, n, len);
      chk({nm, "_vals"}, pack_vals(), vals);
   endtask

   // Back-pressure generator: tied high, or ~50% duty with stalls capped at 8 cycles
   initial begin
      int stall = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) begin
            enc_rdy = 1'b1;
         end else if (stall >= 8 || $urandom_range(0, 1) == 1) begin
            enc_rdy = 1'b1;
            stall = 0;
         end else begin
            enc_rdy = 1'b0;
            stall++;
         end
      end
   end

   // Compare process: every offered bin against the reference queue, stall stability, done timing
   initial begin
      bit         held_vld = 0;
      logic       held_val;
      logic       held_ep;
      logic [9:0] held_ctx;
      bin_t       e;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_vld = 0;
         end else begin
            if (pend_done) begin
               chk("done_pulse", dqp_done_intr, 1);
               chk("done_vld_low", bin_vld, 0);
               pend_done = 0;
               done_cnt++;
            end else begin
               chk("no_spurious_done", dqp_done_intr, 0);
            end
            if (bin_vld) begin
               if (held_vld) begin
                  chk("stall_val", bin_val, held_val);
                  chk("stall_ep", EPMode_enc, held_ep);
                  chk("stall_ctx", ctx_enc_addr, held_ctx);
               end
               if (exp_q.size() == 0) begin
                  chk("extra_bin", 1, 0);
               end else begin
                  e = exp_q[0];
                  chk("bin_val", bin_val, e.v);
                  chk("bin_ep", EPMode_enc, e.ep);
                  if (!e.ep) chk("bin_ctx", ctx_enc_addr, e.ctx);
                  if (enc_rdy) begin
                     void'(exp_q.pop_front());
                     xfer_cnt++;
                     if (exp_q.size() == 0) pend_done = 1;
                  end
               end
               held_vld = !enc_rdy;
               held_val = bin_val;
               held_ep  = EPMode_enc;
               held_ctx = ctx_enc_addr;
            end else begin
               held_vld = 0;
            end
         end
      end
   end

   task automatic start_elem(input int dqp, input int st, input int f, input int md);
      int n;
      n = build(dqp, st, f);
      exp_q    = tmp_q;
      xfer_cnt = 0;
      rdy_mode = md;
      @(posedge clk); #1;
      dqp_start       = 1'b1;
      dqp_val         = dqp[6:0];
      slice_type      = st[1:0];
      cabac_init_flag = f[0];
      @(posedge clk); #1;
      dqp_start       = 1'b0;
      dqp_val         = 7'h55;
      slice_type      = 2'd3;
      cabac_init_flag = ~cabac_init_flag;
      @(negedge clk);
      chk("start_latency", bin_vld, 1);
   endtask

   task automatic run(input int dqp, input int st, input int f, input int md);
      int d0;
      bit got;
      d0 = done_cnt;
      start_elem(dqp, st, f, md);
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk); #1;
         if (done_cnt != d0) got = 1;
      end
      chk("done_seen", got, 1);
      chk("bin_count", xfer_cnt, tmp_q.size());
   endtask

   initial begin
      // Hand-computed pins on the reference itself
      pin("pin_zero", 0, 2, 0, 1, 'b0);
      pin("pin_p3", 3, 1, 0, 5, 'b11100);
      chk("pin_p3_ctx0", tmp_q[0].ctx, 182);
      chk("pin_p3_ctx1", tmp_q[1].ctx, 183);
      pin("pin_m7", -7, 0, 0, 9, 'b111111011);
      chk("pin_m7_ctx0", tmp_q[0].ctx, 184);
      chk("pin_m7_ctx4", tmp_q[4].ctx, 185);
      pin("pin_m64", -64, 2, 0, 17, 'b11111111110111001);
      pin("pin_p5", 5, 1, 1, 7, 'b1111100);
      pin("pin_p1", 1, 2, 0, 3, 'b100);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_vld", bin_vld, 0);
      chk("rst_val", bin_val, 0);
      chk("rst_ep", EPMode_enc, 0);
      chk("rst_ctx", ctx_enc_addr, 0);
      chk("rst_done", dqp_done_intr, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run(0, 2, 0, 0);
      run(3, 1, 0, 0);
      run(-7, 0, 0, 0);
      run(-64, 2, 0, 0);
      run(5, 1, 1, 1);
      run(63, 0, 1, 1);
      run(-1, 3, 1, 0);
      run(4, 1, 1, 1);
      run(-20, 0, 1, 1);

      // Reset in the middle of the suffix of a long element
      start_elem(-64, 2, 0, 0);
      for (int i = 0; i < 100 && xfer_cnt < 7; i++) begin
         @(negedge clk); #1;
      end
      chk("reached_suffix", int'(xfer_cnt >= 7), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      pend_done = 0;
      @(negedge clk);
      chk("mid_rst_vld", bin_vld, 0);
      chk("mid_rst_val", bin_val, 0);
      chk("mid_rst_ep", EPMode_enc, 0);
      chk("mid_rst_ctx", ctx_enc_addr, 0);
      chk("mid_rst_done", dqp_done_intr, 0);
      repeat (4) @(negedge clk);
      run(1, 2, 0, 0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
